// File: rtl/alu_operand_stage.sv
// Registered operand-select stage feeding the ALU: forwarding, operand muxing and a
// 2-entry (main + skid) valid/ready buffer so the ALU sees flop outputs at 1 op/cycle.
module alu_operand_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic [XLEN-1:0]       rs1_data,
   input  logic [XLEN-1:0]       rs2_data,
   input  logic [XLEN-1:0]       imm,
   input  logic [XLEN-1:0]       pc,
   input  logic [1:0]            op1_sel,
   input  logic [1:0]            op2_sel,
   input  logic [3:0]            alu_sel_in,
   input  logic [REG_ADDR_W-1:0] rd_addr_in,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [XLEN-1:0]       wb_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       op1,
   output logic [XLEN-1:0]       op2,
   output logic [3:0]            aluSel,
   output logic [REG_ADDR_W-1:0] rd_addr
);

   typedef struct packed {
      logic [XLEN-1:0]       op1;
      logic [XLEN-1:0]       op2;
      logic [3:0]            alu_sel;
      logic [REG_ADDR_W-1:0] rd;
   } entry_t;

   entry_t          main_q;
   entry_t          skid_q;
   entry_t          new_entry;
   logic            main_valid;
   logic            skid_valid;
   logic            accept;
   logic            xfer;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;

   logic main_load_skid;
   logic main_load_new;
   logic skid_load_new;
   logic main_valid_next;
   logic skid_valid_next;

   assign accept = in_valid && in_ready;
   assign xfer   = main_valid && out_ready;

   // Forwarding only applies to the incoming op; x0 is hardwired zero and never forwarded.
   always_comb begin
      src1 = rs1_data;
      src2 = rs2_data;
      if (wb_en && (wb_addr == rs1_addr) && (rs1_addr != '0)) begin
         src1 = wb_data;
      end
      if (wb_en && (wb_addr == rs2_addr) && (rs2_addr != '0)) begin
         src2 = wb_data;
      end
   end

   always_comb begin
      new_entry         = '0;
      new_entry.alu_sel = alu_sel_in;
      new_entry.rd      = rd_addr_in;
      case (op1_sel)
         2'd0:    new_entry.op1 = src1;
         2'd1:    new_entry.op1 = pc;
         default: new_entry.op1 = '0;
      endcase
      case (op2_sel)
         2'd0:    new_entry.op2 = src2;
         2'd1:    new_entry.op2 = imm;
         2'd2:    new_entry.op2 = XLEN'(4);
         default: new_entry.op2 = '0;
      endcase
   end

   // The skid entry is older than anything arriving now, so it always refills main first.
   always_comb begin
      main_load_skid  = 1'b0;
      main_load_new   = 1'b0;
      skid_load_new   = 1'b0;
      main_valid_next = main_valid;
      skid_valid_next = skid_valid;
      if (!main_valid || xfer) begin
         if (skid_valid) begin
            main_load_skid  = 1'b1;
            main_valid_next = 1'b1;
            skid_load_new   = accept;
            skid_valid_next = accept;
         end else begin
            main_load_new   = accept;
            main_valid_next = accept;
         end
      end else if (accept) begin
         skid_load_new   = 1'b1;
         skid_valid_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b0;
      end else begin
         if (main_load_skid) begin
            main_q <= skid_q;
         end else if (main_load_new) begin
            main_q <= new_entry;
         end
         if (skid_load_new) begin
            skid_q <= new_entry;
         end
         main_valid <= main_valid_next;
         skid_valid <= skid_valid_next;
         in_ready   <= !skid_valid_next;
      end
   end

   assign out_valid = main_valid;
   assign op1       = main_q.op1;
   assign op2       = main_q.op2;
   assign aluSel    = main_q.alu_sel;
   assign rd_addr   = main_q.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vector table, backpressure and
// reset sequences, and a random stream checked against a queue-based reference model.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] imm;
   logic [31:0] pc;
   logic [1:0]  op1_sel;
   logic [1:0]  op2_sel;
   logic [3:0]  alu_sel_in;
   logic [4:0]  rd_addr_in;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [3:0]  aluSel;
   logic [4:0]  rd_addr;

   int checks   = 0;
   int failures = 0;
   int received = 0;

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  alu;
      logic [4:0]  rd;
   } exp_t;

   typedef struct {
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [1:0]  op1_sel;
      logic [1:0]  op2_sel;
      logic [3:0]  alu_sel;
      logic [4:0]  rd;
      logic        wb_en;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic [31:0] e_op1;
      logic [31:0] e_op2;
      logic [3:0]  e_alu;
   } vec_t;

   exp_t        model_q[$];
   logic [31:0] op2_log[$];
   vec_t        vecs[8];

   alu_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .imm(imm), .pc(pc), .op1_sel(op1_sel), .op2_sel(op2_sel), .alu_sel_in(alu_sel_in),
      .rd_addr_in(rd_addr_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2),
      .aluSel(aluSel), .rd_addr(rd_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // What the ALU should receive for the op currently presented upstream.
   function automatic exp_t model_entry();
      exp_t        e;
      logic [31:0] s1;
      logic [31:0] s2;
      s1 = rs1_data;
      s2 = rs2_data;
      if (wb_en && rs1_addr != 0 && wb_addr == rs1_addr) s1 = wb_data;
      if (wb_en && rs2_addr != 0 && wb_addr == rs2_addr) s2 = wb_data;
      e.op1 = (op1_sel == 0) ? s1 : (op1_sel == 1) ? pc : 32'd0;
      e.op2 = (op2_sel == 0) ? s2 : (op2_sel == 1) ? imm : (op2_sel == 2) ? 32'd4 : 32'd0;
      e.alu = alu_sel_in;
      e.rd  = rd_addr_in;
      return e;
   endfunction

   // One clock: score any transfer and accept seen at this edge, then check occupancy.
   task automatic apply_stimulus();
      logic        acc;
      logic        xf;
      logic        stalled;
      exp_t        e;
      exp_t        held;
      acc     = in_valid && in_ready;
      xf      = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      held    = '{op1, op2, aluSel, rd_addr};
      if (xf) begin
         if (model_q.size() == 0) begin
            check_output("spurious_transfer", 32'd1, 32'd0);
         end else begin
            e = model_q.pop_front();
            check_output("xfer_op1", op1, e.op1);
            check_output("xfer_op2", op2, e.op2);
            check_output("xfer_alusel", {28'd0, aluSel}, {28'd0, e.alu});
            check_output("xfer_rd", {27'd0, rd_addr}, {27'd0, e.rd});
            op2_log.push_back(op2);
            received++;
         end
      end
      if (acc) model_q.push_back(model_entry());
      @(posedge clk);
      #1;
      check_output("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
      check_output("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
      if (stalled) begin
         check_output("hold_op1", op1, held.op1);
         check_output("hold_op2", op2, held.op2);
         check_output("hold_alusel", {28'd0, aluSel}, {28'd0, held.alu});
         check_output("hold_rd", {27'd0, rd_addr}, {27'd0, held.rd});
      end
   endtask

   task automatic drive_vec(input vec_t v);
      rs1_addr   = v.rs1_addr;
      rs2_addr   = v.rs2_addr;
      rs1_data   = v.rs1_data;
      rs2_data   = v.rs2_data;
      imm        = v.imm;
      pc         = v.pc;
      op1_sel    = v.op1_sel;
      op2_sel    = v.op2_sel;
      alu_sel_in = v.alu_sel;
      rd_addr_in = v.rd;
      wb_en      = v.wb_en;
      wb_addr    = v.wb_addr;
      wb_data    = v.wb_data;
   endtask

   task automatic randomize_fields(input int tag);
      rs1_addr   = 5'($urandom_range(0, 3));
      rs2_addr   = 5'($urandom_range(0, 3));
      rs1_data   = $urandom;
      rs2_data   = $urandom;
      imm        = 32'(tag);
      pc         = $urandom;
      op1_sel    = 2'($urandom_range(0, 3));
      op2_sel    = 2'($urandom_range(0, 3));
      alu_sel_in = 4'($urandom_range(0, 15));
      rd_addr_in = 5'(tag);
      wb_en      = 1'($urandom_range(0, 1));
      wb_addr    = 5'($urandom_range(0, 3));
      wb_data    = $urandom;
   endtask

   initial begin
      int idx;
      int cyc;
      int sent;
      logic acc;

      vecs[0] = '{5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 32'd0, 2'd0, 2'd0, 4'd0, 5'd1,
                  1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 4'd0};
      vecs[1] = '{5'd3, 5'd4, 32'd1, 32'd9, 32'd0, 32'd0, 2'd0, 2'd0, 4'd1, 5'd2,
                  1'b1, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'd9, 4'd1};
      vecs[2] = '{5'd0, 5'd4, 32'd1, 32'd9, 32'd0, 32'd0, 2'd0, 2'd0, 4'd2, 5'd3,
                  1'b1, 5'd0, 32'hDEADBEEF, 32'd1, 32'd9, 4'd2};
      vecs[3] = '{5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 32'h1000, 2'd1, 2'd2, 4'd3, 5'd4,
                  1'b0, 5'd0, 32'd0, 32'h1000, 32'd4, 4'd3};
      vecs[4] = '{5'd1, 5'd2, 32'd5, 32'd7, 32'hFFFFFFF0, 32'h1000, 2'd1, 2'd1, 4'd4, 5'd5,
                  1'b0, 5'd0, 32'd0, 32'h1000, 32'hFFFFFFF0, 4'd4};
      vecs[5] = '{5'd1, 5'd6, 32'd5, 32'd7, 32'h55, 32'h20, 2'd2, 2'd3, 4'd15, 5'd6,
                  1'b1, 5'd6, 32'hCAFE, 32'd0, 32'd0, 4'd15};
      vecs[6] = '{5'd1, 5'd6, 32'd5, 32'd7, 32'd0, 32'd0, 2'd3, 2'd0, 4'd10, 5'd7,
                  1'b1, 5'd6, 32'h1234, 32'd0, 32'h1234, 4'd10};
      vecs[7] = '{5'd8, 5'd8, 32'hA, 32'hB, 32'd0, 32'd0, 2'd0, 2'd0, 4'd9, 5'd31,
                  1'b1, 5'd8, 32'h77, 32'h77, 32'h77, 4'd9};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      drive_vec(vecs[0]);
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_output("rst_op1", op1, 32'd0);
      check_output("rst_op2", op2, 32'd0);
      check_output("rst_alusel", {28'd0, aluSel}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_output("release_in_ready", {31'd0, in_ready}, 32'd1);

      // Directed table, one op at a time.
      for (int i = 0; i < 8; i++) begin
         drive_vec(vecs[i]);
         in_valid  = 1'b1;
         out_ready = 1'b1;
         apply_stimulus();
         in_valid = 1'b0;
         check_output($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
         check_output($sformatf("vec%0d_op1", i), op1, vecs[i].e_op1);
         check_output($sformatf("vec%0d_op2", i), op2, vecs[i].e_op2);
         check_output($sformatf("vec%0d_alusel", i), {28'd0, aluSel}, {28'd0, vecs[i].e_alu});
         check_output($sformatf("vec%0d_rd", i), {27'd0, rd_addr}, {27'd0, vecs[i].rd});
         apply_stimulus();
      end

      // Backpressure: A,B,C,D back-to-back while the ALU stalls.
      op2_log.delete();
      drive_vec(vecs[0]);
      op2_sel   = 2'd1;
      out_ready = 1'b0;
      idx = 0;
      for (int k = 0; k < 6; k++) begin
         in_valid = (idx < 4);
         imm = 32'hA0 + 32'(idx);
         acc = in_valid && in_ready;
         apply_stimulus();
         if (acc) idx++;
      end
      check_output("bp_accepted", 32'(idx), 32'd2);
      check_output("bp_head_op2", op2, 32'hA0);
      check_output("bp_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      cyc = 0;
      while ((op2_log.size() < 4) && (cyc < 20)) begin
         in_valid = (idx < 4);
         imm = 32'hA0 + 32'(idx);
         acc = in_valid && in_ready;
         apply_stimulus();
         if (acc) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      check_output("bp_count", 32'(op2_log.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < op2_log.size()) check_output($sformatf("bp_order%0d", k), op2_log[k], 32'hA0 + 32'(k));
      end
      apply_stimulus();

      // Random stream with tags in imm / rd.
      received = 0;
      sent = 0;
      cyc = 0;
      acc = 1'b1;
      while ((received < 1000) && (cyc < 20000)) begin
         if (!in_valid || acc) begin
            in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
            randomize_fields(sent);
         end
         out_ready = ($urandom_range(0, 1) == 1);
         acc = in_valid && in_ready;
         apply_stimulus();
         if (acc) sent++;
         cyc++;
      end
      in_valid = 1'b0;
      check_output("rand_received", 32'(received), 32'd1000);

      // Reset with both entries occupied.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      cyc = 0;
      while ((model_q.size() < 2) && (cyc < 10)) begin
         randomize_fields(cyc);
         apply_stimulus();
         cyc++;
      end
      check_output("full_before_reset", 32'(model_q.size()), 32'd2);
      in_valid = 1'b0;
      rst = 1'b1;
      model_q.delete();
      @(posedge clk);
      #1;
      check_output("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check_output("midrst_op1", op1, 32'd0);
      check_output("midrst_op2", op2, 32'd0);
      check_output("midrst_alusel", {28'd0, aluSel}, 32'd0);
      check_output("midrst_rd", {27'd0, rd_addr}, 32'd0);
      check_output("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_output("postrst_in_ready", {31'd0, in_ready}, 32'd1);
      check_output("postrst_out_valid", {31'd0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered operand-select stage directly upstream of the ALU.
- Takes decoded instruction fields and register-file read data, and selects op1/op2.
- Applies writeback forwarding, then presents op1, op2 and aluSel to the ALU from registers.
- Uses a valid/ready handshake with a 2-entry skid buffer, so it sustains 1 op/cycle and the ALU inputs are glitch-free flop outputs.

Parameters:
XLEN, 32, datapath width (op1/op2/imm/pc/wb_data)
REG_ADDR_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream has a decoded op
in_ready  out  1  stage can accept (registered)
rs1_addr  in  REG_ADDR_W  source 1 index
rs2_addr  in  REG_ADDR_W  source 2 index
rs1_data  in  XLEN  regfile read 1
rs2_data  in  XLEN  regfile read 2
imm  in  XLEN  sign-extended immediate
pc  in  XLEN  instruction address
op1_sel  in  2  0=rs1, 1=pc, 2=zero, 3=reserved(zero)
op2_sel  in  2  0=rs2, 1=imm, 2=constant 4, 3=reserved(zero)
alu_sel_in  in  4  ALUSel code: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, COPY1=10
rd_addr_in  in  REG_ADDR_W  destination, passed through
wb_en  in  1  writeback valid this cycle
wb_addr  in  REG_ADDR_W  writeback destination
wb_data  in  XLEN  writeback value
out_valid  out  1  op1/op2/aluSel valid
out_ready  in  1  ALU/downstream accepts
op1  out  XLEN  to ALU op1
op2  out  XLEN  to ALU op2
aluSel  out  4  to ALU aluSel (same encoding as alu_sel_in)
rd_addr  out  REG_ADDR_W  passed-through destination

Behaviour:
- Accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Forwarding is evaluated combinationally at accept time only.
  - src1 = wb_data if wb_en && wb_addr==rs1_addr && rs1_addr!=0; otherwise rs1_data. src2 is formed the same way from rs2.
  - x0 is never forwarded.
  - Entries already held in main/skid are not re-forwarded; upstream hazard logic owns that.
- Operand mux, applied before capture:
  - op1: rs1→src1, pc→pc, zero/reserved→0.
  - op2: rs2→src2, imm→imm, 4→XLEN'(4), reserved→0.
  - alu_sel_in values 11..15 are captured unchanged; the ALU default handles them.
- Storage: main register (drives outputs) and skid register, each with a valid bit.
- Per cycle, by priority:
  - main empty or output transfer: main loads skid if skid valid, else loads the accepted entry (if any). An accept in the same cycle that skid drains goes into skid.
  - main full, no output transfer, accept: entry goes to skid.
  - skid valid cleared when it moves to main.
- in_ready = registered !skid_valid_next. It is never combinational from out_ready.
- Latency: accept in cycle N → out_valid in N+1 when main was empty or draining.
- Throughput: 1 op/cycle with out_ready held high.
- Ordering: strict FIFO; no drops, no duplicates.
- Output stability: while out_valid && !out_ready, op1/op2/aluSel/rd_addr are held.
- Reset (synchronous, overrides all):
  - out_valid=0, skid valid=0, in_ready=0 while rst high, 1 in the first cycle after release.
  - op1=0, op2=0, aluSel=0 (ADD), rd_addr=0.
  - Reset mid-operation discards both entries; no transfer is reported in the reset cycle.
- Simultaneous full-skid + output transfer: skid→main, in_ready rises next cycle. An accept cannot occur that cycle because in_ready was 0.

Test Plan:
- Reset release, in_valid=1, rs1_data=5, rs2_data=7, sel=0/0, alu_sel_in=0, out_ready=1 → out_valid 1 cycle later with op1=5, op2=7, aluSel=0.
- Forwarding: rs1_addr=3, rs1_data=1, wb_en=1, wb_addr=3, wb_data=0xDEADBEEF → op1=0xDEADBEEF.
  - Repeat with rs1_addr=0, wb_addr=0 → op1=rs1_data.
- Mux: op1_sel=1, pc=0x1000, op2_sel=2 → op1=0x1000, op2=4. Then op2_sel=1, imm=0xFFFFFFF0 → op2=0xFFFFFFF0.
- Backpressure: stream ops A,B,C,D back-to-back with out_ready=0 from the cycle A appears.
  - A held on outputs, B in skid, in_ready=0; C held upstream.
  - Release out_ready → A,B,C,D emerge in order, no loss or duplicates.
- Random in_valid/out_ready (50%), 1000 ops with sequence tags in imm → output order equals input order, held outputs stable while stalled.
- Assert rst with both entries full → next cycle out_valid=0, op1=op2=0, aluSel=0; in_ready=1 the cycle after release.
